// File: rtl/lamp_pkg.sv
// lamp_pkg: shared state encodings and bit-timing helpers for the lamp's serial and LED paths.
package lamp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    function automatic int cnt_width(input int cpb);
        return (cpb < 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/lamp_sync.sv
// lamp_sync: generic 2-FF synchronizer with async reset and selectable reset value,
// shared by the UART receiver and the lamp's button inputs.
module lamp_sync #(
    parameter logic c_rst_val = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= c_rst_val;
            r_q    <= c_rst_val;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/lamp_uart_rx.sv
// lamp_uart_rx: 8N1 UART command receiver delivering one byte per frame to the lamp logic.
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop bits.
module lamp_uart_rx
    import lamp_pkg::*;
#(
    parameter int c_freq = 12000000,
    parameter int c_baud = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_parity_err
);

    localparam int c_clks_per_bit = clks_per_bit(c_freq, c_baud);
    localparam int c_cnt_w        = cnt_width(c_clks_per_bit);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(c_clks_per_bit / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(c_clks_per_bit - 1);

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_valid;
    logic               r_frame_err;

    logic w_rx;
    logic w_half;
    logic w_full;
    logic w_cnt_clr;
    logic w_shift;
    logic w_load;
    logic w_frame;

    lamp_sync #(.c_rst_val(1'b1)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx)
    );

    assign w_half = (r_cnt == c_half_m1);
    assign w_full = (r_cnt == c_full_m1);

`ifdef UART_RX_PARITY_EN
    logic r_par;
    logic r_parity_err;
    logic w_par_smp;
    logic w_perr;
    logic w_par_bad;

    assign w_par_bad    = ^{r_shift, r_par};
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The start check lands one cycle early so that the 2-FF latency is absorbed and
    // every later sample sits at the middle of its bit.
    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_shift   = 1'b0;
        w_load    = 1'b0;
        w_frame   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_smp = 1'b0;
        w_perr    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_cnt_clr = 1'b1;
                    w_next    = START;
                end
            end
            START: begin
                if (w_half) begin
                    w_cnt_clr = 1'b1;
                    w_next    = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_full) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_full) begin
                    w_cnt_clr = 1'b1;
                    w_par_smp = 1'b1;
                    w_next    = STOP;
                end
            end
`endif
            STOP: begin
                if (w_full) begin
                    w_cnt_clr = 1'b1;
                    if (!w_rx) begin
                        w_frame = 1'b1;
                        w_next  = WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (w_par_bad) begin
                        w_perr = 1'b1;
                        w_next = IDLE;
                    end
`endif
                    else begin
                        w_load = 1'b1;
                        w_next = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_rx) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_valid     <= w_load;
            r_frame_err <= w_frame;
            if (r_state == START) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end
            if (w_load) begin
                r_data <= r_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr;
            if (w_par_smp) begin
                r_par <= w_rx;
            end
        end
    end
`endif

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_lamp_uart_rx.sv
// tb_lamp_uart_rx: directed bench for the lamp UART receiver at 10 clocks per bit.
// Honours UART_RX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_lamp_uart_rx;
    import lamp_pkg::*;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Pulse is registered on the stop-sample edge t0+2+half+(FRAME_BITS-1)*CPB and is
    // therefore seen at the following falling edge, one cycle before t0+3+half+...
    localparam int PULSE_OFS = 2 + HALF + (FRAME_BITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxLine;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameErr;
    logic       oParityErr;

    int   cyc = 0;
    int   assertCount = 0;
    int   failCount = 0;
    int   validCount = 0;
    int   frameCount = 0;
    int   perrCount = 0;
    logic [7:0] validData[$];
    int         validCyc[$];
    int   lastT0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       parBit;
        int         expValid;
        int         expFrame;
        int         expPerr;
        logic [7:0] expData;
    } vec_t;
    vec_t vecs[$];

    lamp_uart_rx #(.c_freq(10000000), .c_baud(1000000)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rxLine),
        .o_data       (oData),
        .o_valid      (oValid),
        .o_frame_err  (oFrameErr),
        .o_parity_err (oParityErr)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every high sample is counted, so a pulse wider than one cycle shows up as an extra count.
    always @(negedge clk) begin
        if (oValid) begin
            validCount++;
            validData.push_back(oData);
            validCyc.push_back(cyc);
        end
        if (oFrameErr) frameCount++;
        if (oParityErr) perrCount++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    // Must be called at a falling edge; lastT0 is the first rising edge that sees the start bit.
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic parBit);
        lastT0 = cyc + 1;
        rxLine = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxLine = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxLine = parBit;
        repeat (CPB) @(negedge clk);
`else
        if (parBit !== ^d) $display("[TB] note: parity bit ignored in 8N1 build");
`endif
        rxLine = stopBit;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int vBase;
        int fBase;
        int pBase;
        int t0a;
        logic [7:0] c3;

        rst    = 1'b1;
        rxLine = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset o_data", int'(oData), 0);
        checkOutput("reset o_valid", int'(oValid), 0);
        checkOutput("reset o_frame_err", int'(oFrameErr), 0);
        checkOutput("reset o_parity_err", int'(oParityErr), 0);
        checkOutput("reset state", int'(dut.r_state), int'(IDLE));
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        vecs.push_back('{8'hA5, 1'b1, ^8'hA5, 1, 0, 0, 8'hA5});
        vecs.push_back('{8'h3C, 1'b1, ^8'h3C, 1, 0, 0, 8'h3C});
        vecs.push_back('{8'h01, 1'b1, ^8'h01, 1, 0, 0, 8'h01});
        vecs.push_back('{8'h80, 1'b1, ^8'h80, 1, 0, 0, 8'h80});
        vecs.push_back('{8'h55, 1'b0, ^8'h55, 0, 1, 0, 8'h80});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 0, 0, 8'h07});
        vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 0, 1, 8'h07});
`endif

        foreach (vecs[k]) begin
            vBase = validCount;
            fBase = frameCount;
            pBase = perrCount;
            applyStimulus(vecs[k].data, vecs[k].stopBit, vecs[k].parBit);
            rxLine = 1'b1;
            repeat (2 * CPB) @(negedge clk);
            checkOutput($sformatf("vec%0d valid count", k), validCount - vBase, vecs[k].expValid);
            checkOutput($sformatf("vec%0d frame_err count", k), frameCount - fBase, vecs[k].expFrame);
            checkOutput($sformatf("vec%0d parity_err count", k), perrCount - pBase, vecs[k].expPerr);
            checkOutput($sformatf("vec%0d o_data", k), int'(oData), int'(vecs[k].expData));
            if (vecs[k].expValid == 1 && validCount > vBase) begin
                checkOutput($sformatf("vec%0d valid timing", k), validCyc[vBase], lastT0 + PULSE_OFS);
                checkOutput($sformatf("vec%0d captured byte", k), int'(validData[vBase]), int'(vecs[k].expData));
            end
        end

        // Back-to-back frames with a single stop bit between them.
        vBase = validCount;
        applyStimulus(8'h00, 1'b1, 1'b0);
        t0a = lastT0;
        applyStimulus(8'hFF, 1'b1, 1'b0);
        rxLine = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("b2b valid count", validCount - vBase, 2);
        if (validCount - vBase == 2) begin
            checkOutput("b2b first byte", int'(validData[vBase]), 8'h00);
            checkOutput("b2b second byte", int'(validData[vBase + 1]), 8'hFF);
            checkOutput("b2b first timing", validCyc[vBase], t0a + PULSE_OFS);
            checkOutput("b2b spacing", validCyc[vBase + 1] - validCyc[vBase], FRAME_BITS * CPB);
        end

        // Three-cycle glitch must be rejected at the half-bit check.
        vBase = validCount;
        fBase = frameCount;
        rxLine = 1'b0;
        repeat (3) @(negedge clk);
        rxLine = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("glitch valid count", validCount - vBase, 0);
        checkOutput("glitch frame_err count", frameCount - fBase, 0);
        checkOutput("glitch state", int'(dut.r_state), int'(IDLE));
        applyStimulus(8'h3C, 1'b1, ^8'h3C);
        rxLine = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("after glitch valid count", validCount - vBase, 1);
        checkOutput("after glitch o_data", int'(oData), 8'h3C);

        // Break: stop bit low and the line held low for 30 more bit periods.
        vBase = validCount;
        fBase = frameCount;
        applyStimulus(8'h55, 1'b0, ^8'h55);
        repeat (30 * CPB) @(negedge clk);
        rxLine = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("break frame_err count", frameCount - fBase, 1);
        checkOutput("break valid count", validCount - vBase, 0);
        checkOutput("break o_data held", int'(oData), 8'h3C);
        applyStimulus(8'hA5, 1'b1, ^8'hA5);
        rxLine = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("after break valid count", validCount - vBase, 1);
        checkOutput("after break o_data", int'(oData), 8'hA5);

        // Reset asserted in the middle of data bit 4 of 8'hC3 and held to the end of the frame.
        vBase = validCount;
        c3 = 8'hC3;
        rxLine = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxLine = c3[i];
            repeat (CPB) @(negedge clk);
        end
        rxLine = c3[4];
        repeat (HALF) @(negedge clk);
        #10 rst = 1'b1;
        #1;
        checkOutput("mid-frame reset o_data", int'(oData), 0);
        checkOutput("mid-frame reset o_valid", int'(oValid), 0);
        checkOutput("mid-frame reset state", int'(dut.r_state), int'(IDLE));
        @(negedge clk);
        repeat (HALF - 1) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            rxLine = c3[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rxLine = ^c3;
        repeat (CPB) @(negedge clk);
`endif
        rxLine = 1'b1;
        repeat (CPB) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("aborted frame valid count", validCount - vBase, 0);
        checkOutput("aborted frame o_data", int'(oData), 0);
        applyStimulus(8'h81, 1'b1, ^8'h81);
        rxLine = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("after reset valid count", validCount - vBase, 1);
        checkOutput("after reset o_data", int'(oData), 8'h81);
        if (validCount > vBase) begin
            checkOutput("after reset valid timing", validCyc[vBase], lastT0 + PULSE_OFS);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/lamp_uart_rx.md
# lamp_uart_rx

Serial command receiver for the lamp: samples an asynchronous 8N1 UART line and delivers one byte per frame to the lamp control logic. It is the input-side counterpart of the lamp's LED output path: the host-facing end where brightness and mode commands enter the FPGA. Bit timing is derived from the system clock frequency parameter in the same way as the lamp's LED timing.

## Interface
Parameters:
- c_freq, 12000000, system clock frequency in Hz.
- c_baud, 115200, line baud rate. c_clks_per_bit = c_freq / c_baud (integer truncation); must be >= 4.

Ports:
- i_clk  input  1  system clock. One clock domain; everything is registered on its rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_rx  input  1  UART line, idle high, asynchronous to i_clk.
- o_data  output  8  last received byte, LSB received first.
- o_valid  output  1  one-cycle pulse when o_data holds a new, error-free byte.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
- o_parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without parity.

## Operation
- i_rx passes through a 2-FF synchronizer, reset to 1. All decisions use the synchronized value rx_s.
- Bit counter counts 0..c_clks_per_bit-1. The half-bit point is c_clks_per_bit/2 (truncated).
- States:
  - IDLE: wait for rx_s = 0, then clear the counter and go to START.
  - START: at the half-bit point, if rx_s = 1 the start was a glitch; go to IDLE with no output. If rx_s = 0, restart the counter and go to DATA.
  - DATA: sample rx_s each full bit period, 8 samples, shifted in LSB-first; then go to PARITY (if enabled) or STOP.
  - PARITY: sample one bit; even parity over the 8 data bits plus the parity bit must be 0.
  - STOP: sample one bit.
    - If it is 1 and no parity error: load o_data, pulse o_valid, go to IDLE.
    - If it is 0: pulse o_frame_err, leave o_data unchanged, go to WAIT_HIGH.
    - If it is 1 but parity failed: pulse o_parity_err, leave o_data unchanged, go to IDLE.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. A break condition therefore produces exactly one o_frame_err.
- Frame and parity errors are never reported together. Frame error takes precedence.
- o_data is held until the next valid byte.

## Timing
- Reset values: o_data = 8'h00, o_valid = 0, o_frame_err = 0, o_parity_err = 0, state = IDLE, synchronizer = 1.
- Reset asserted mid-frame aborts immediately. The partial byte is discarded and no pulse is issued.
- Sample point of data bit n (0..7): at t0 + 2 + half + (n+1)·c_clks_per_bit cycles.
  - t0 is the first i_clk edge at which i_rx is low.
  - half = c_clks_per_bit/2.
- Output pulses occur in the cycle after the stop-bit sample, i.e. at t0 + 3 + half + 9·c_clks_per_bit without parity (10· with parity). Each pulse lasts exactly one cycle.
- Back-to-back frames: a new start bit is accepted from the first IDLE cycle. No inter-frame gap beyond the stop bit is required.
- Throughput is at most one byte per 10 (11 with parity) bit periods.

## Configuration
- Macro UART_RX_PARITY_EN.
- Defined: an even parity bit is expected between the data bits and the stop bit, and o_parity_err is active.
- Undefined: no PARITY state, frames are 8N1, and o_parity_err is tied to 0.

## Structure
- Shared include lamp_pkg.vh holds:
  - state encodings (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH) as localparams;
  - a macro or function computing c_clks_per_bit and the counter width ($clog2).
- Sub-module lamp_sync: a generic 2-FF synchronizer with async reset and a reset-value parameter. It is reused for the lamp's button inputs.

## Test plan
Bench setup: c_freq = 10000000, c_baud = 1000000 (10 clocks/bit), 10 MHz clock as in the lamp bench.

1. Send 8'hA5 as 8N1 → o_valid pulses once for 1 cycle at the computed offset, o_data = 8'hA5, both error outputs stay 0.
2. Send 8'h00 then 8'hFF back-to-back with one stop bit each → two o_valid pulses 10 bit periods apart, with o_data = 8'h00 then 8'hFF.
3. Drive i_rx low for 3 cycles, then high → no pulses; state returns to IDLE; a following 8'h3C is received correctly.
4. Send 8'h55 with the stop bit low, holding the line low for 30 more bit periods → exactly one o_frame_err pulse, no o_valid, o_data keeps its previous value; the next frame after the line goes high is received.
5. Assert i_rst during data bit 4 of 8'hC3 → outputs return to reset values immediately; no o_valid for that frame; the next frame 8'h81 is received.
6. With UART_RX_PARITY_EN: 8'h07 with parity 1 → o_valid, o_data = 8'h07. The same byte with parity 0 → one o_parity_err pulse, no o_valid.
